// File: rtl/ulpi_pkg.sv
`default_nettype none
// ============================================================================
// ulpi_pkg: RxCMD field layout, receive event codes, flag indices, FSM states.
// Rev 1.0
// ============================================================================
package ulpi_pkg;

    localparam int RXCMD_LS_LSB   = 0;
    localparam int RXCMD_VBUS_LSB = 2;
    localparam int RXCMD_EVT_LSB  = 4;
    localparam int RXCMD_ID_BIT   = 6;

    localparam logic [1:0] RX_EVENT_ACTIVE    = 2'b01;
    localparam logic [1:0] RX_EVENT_HOST_DISC = 2'b10;
    localparam logic [1:0] RX_EVENT_ERROR     = 2'b11;

    localparam int FLAG_HOST_DISC = 0;
    localparam int FLAG_TOO_LONG  = 1;
    localparam int FLAG_TRUNC     = 2;
    localparam int FLAG_RX_ERROR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_RECV   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // RxActive is asserted for both the plain active and the error event.
    function automatic logic evt_is_active(input logic [1:0] evt);
        return (evt == RX_EVENT_ACTIVE) || (evt == RX_EVENT_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_fifo_commit.sv
`default_nettype none
// ============================================================================
// pkt_fifo_commit: byte FIFO with speculative writes, commit and rollback.
// Rev 1.0
// ============================================================================
module pkt_fifo_commit #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    input  logic          commit,
    input  logic          rollback,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [AW:0]   spec_ptr;
    logic [AW:0]   cmt_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [2**AW];
    logic          do_wr;
    logic          do_rd;

    // Space is judged against the speculative pointer; readers only see committed bytes.
    assign full  = (spec_ptr[AW] != rd_ptr[AW]) && (spec_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (cmt_ptr == rd_ptr);
    assign level = cmt_ptr - rd_ptr;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[spec_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_ptr <= '0;
            cmt_ptr  <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_vld   <= 1'b0;
        end else begin
            if (rollback)
                spec_ptr <= cmt_ptr;
            else if (do_wr)
                spec_ptr <= spec_ptr + 1'b1;
            if (commit)
                cmt_ptr <= spec_ptr;
            rd_vld <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ulpi_rx_pkt_capture.sv
`default_nettype none
// ============================================================================
// ulpi_rx_pkt_capture: ULPI receive sniffer storing packets and info words.
// Rev 1.0
// ============================================================================
module ulpi_rx_pkt_capture
    import ulpi_pkg::*;
#(
    parameter int  DATA_AW = 9,
    parameter int  INFO_AW = 5,
    parameter int  LEN_W   = 11,
    parameter int  TS_W    = 16,
    localparam int INFO_W  = 4 + LEN_W + TS_W
) (
    input  logic              clk_ULPI,
    input  logic              rst,
    input  logic              enable,
    input  logic              DIR,
    input  logic              NXT,
    input  logic [7:0]        DATA_I,
    output logic [7:0]        DATA_O,
    output logic              STP,
    input  logic              data_rd_en,
    output logic [7:0]        data_o,
    output logic              data_vld,
    output logic              data_empty,
    output logic [DATA_AW:0]  data_level,
    input  logic              info_rd_en,
    output logic [INFO_W-1:0] info_o,
    output logic              info_vld,
    output logic              info_empty,
    output logic [1:0]        linestate,
    output logic [1:0]        vbus_state,
    output logic              rx_active,
    output logic              rx_error,
    output logic              host_disconnect,
    output logic              id_state,
    output logic              busy,
    output logic              pkt_done,
    output logic [15:0]       drop_count
);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t              state;
    logic                dir_q;
    logic [6:0]          rxcmd;
    logic [TS_W-1:0]     ts;
    logic [LEN_W-1:0]    len;
    logic [3:0]          flags;
    logic [TS_W-1:0]     pkt_ts;
    logic [1:0]          cmd_evt;
    logic [1:0]          cur_evt;
    logic                is_data;
    logic                data_full;
    logic                has_pkt;
    logic                info_full;
    logic                do_commit;
    logic                do_drop;
    logic [INFO_AW:0]    info_wr;
    logic [INFO_AW:0]    info_rd;
    logic [INFO_W-1:0]   info_mem [2**INFO_AW];

    assign DATA_O = 8'h00;
    assign STP    = 1'b0;

    assign cmd_evt         = DATA_I[RXCMD_EVT_LSB +: 2];
    assign cur_evt         = rxcmd[RXCMD_EVT_LSB +: 2];
    assign linestate       = rxcmd[RXCMD_LS_LSB +: 2];
    assign vbus_state      = rxcmd[RXCMD_VBUS_LSB +: 2];
    assign rx_active       = evt_is_active(cur_evt);
    assign rx_error        = (cur_evt == RX_EVENT_ERROR);
    assign host_disconnect = (cur_evt == RX_EVENT_HOST_DISC);
    assign id_state        = rxcmd[RXCMD_ID_BIT];
    assign busy            = (state != ST_IDLE);

    assign is_data    = (state == ST_RECV) && DIR && NXT;
    assign info_empty = (info_wr == info_rd);
    assign info_full  = (info_wr[INFO_AW] != info_rd[INFO_AW]) &&
                        (info_wr[INFO_AW-1:0] == info_rd[INFO_AW-1:0]);
    // An errored packet is reported even when it carried no bytes.
    assign has_pkt    = (len != '0) || flags[FLAG_RX_ERROR];
    assign do_commit  = (state == ST_COMMIT) && has_pkt && !info_full;
    assign do_drop    = (state == ST_COMMIT) && has_pkt && info_full;

    pkt_fifo_commit #(
        .AW (DATA_AW),
        .DW (8)
    ) u_data_fifo (
        .clk      (clk_ULPI),
        .rst      (rst),
        .wr_en    (is_data),
        .wr_data  (DATA_I),
        .full     (data_full),
        .commit   (do_commit),
        .rollback (do_drop),
        .rd_en    (data_rd_en),
        .rd_data  (data_o),
        .rd_vld   (data_vld),
        .empty    (data_empty),
        .level    (data_level)
    );

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            dir_q      <= 1'b0;
            rxcmd      <= '0;
            ts         <= '0;
            len        <= '0;
            flags      <= '0;
            pkt_ts     <= '0;
            pkt_done   <= 1'b0;
            drop_count <= '0;
        end else begin
            dir_q    <= DIR;
            ts       <= ts + 1'b1;
            pkt_done <= do_commit;
            if (do_drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (DIR && !dir_q && enable)
                        state <= ST_TURN;
                end
                ST_TURN, ST_COMMIT: begin
                    len    <= '0;
                    flags  <= '0;
                    pkt_ts <= '0;
                    state  <= DIR ? ST_RECV : ST_IDLE;
                end
                ST_RECV: begin
                    if (!DIR) begin
                        state <= ST_COMMIT;
                    end else if (NXT) begin
                        if (len == '0)
                            pkt_ts <= ts;
                        if (len != LEN_MAX)
                            len <= len + 1'b1;
                        if (len >= LEN_MAX - 1'b1)
                            flags[FLAG_TOO_LONG] <= 1'b1;
                        if (data_full)
                            flags[FLAG_TRUNC] <= 1'b1;
                    end else begin
                        rxcmd <= DATA_I[6:0];
                        if (cmd_evt == RX_EVENT_ERROR)
                            flags[FLAG_RX_ERROR] <= 1'b1;
                        if (cmd_evt == RX_EVENT_HOST_DISC)
                            flags[FLAG_HOST_DISC] <= 1'b1;
                        if (!evt_is_active(cmd_evt))
                            state <= ST_COMMIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ULPI) begin
        if (do_commit)
            info_mem[info_wr[INFO_AW-1:0]] <= {flags, len, pkt_ts};
    end

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            info_wr  <= '0;
            info_rd  <= '0;
            info_o   <= '0;
            info_vld <= 1'b0;
        end else begin
            if (do_commit)
                info_wr <= info_wr + 1'b1;
            info_vld <= info_rd_en && !info_empty;
            if (info_rd_en && !info_empty) begin
                info_o  <= info_mem[info_rd[INFO_AW-1:0]];
                info_rd <= info_rd + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_rx_pkt_capture.sv
`default_nettype none
// ============================================================================
// tb_ulpi_rx_pkt_capture: randomized packet bench against a queue-based model.
// Rev 1.0
// ============================================================================
module tb_ulpi_rx_pkt_capture;
    localparam int DEPTH      = 512;
    localparam int INFO_DEPTH = 32;
    localparam int LEN_MAX    = 2047;

    logic        clk_ULPI = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        DIR = 1'b0;
    logic        NXT = 1'b0;
    logic [7:0]  DATA_I = 8'h00;
    logic        data_rd_en = 1'b0;
    logic        info_rd_en = 1'b0;
    logic [7:0]  DATA_O;
    logic        STP;
    logic [7:0]  data_o;
    logic        data_vld;
    logic        data_empty;
    logic [9:0]  data_level;
    logic [30:0] info_o;
    logic        info_vld;
    logic        info_empty;
    logic [1:0]  linestate;
    logic [1:0]  vbus_state;
    logic        rx_active;
    logic        rx_error;
    logic        host_disconnect;
    logic        id_state;
    logic        busy;
    logic        pkt_done;
    logic [15:0] drop_count;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] tb_ts;
    logic [7:0]  exp_data[$];
    logic [30:0] exp_info[$];
    int          exp_drop;
    logic [7:0]  cur_bytes[$];
    int          cur_len;
    bit          cur_err;
    bit          cur_hd;
    logic [15:0] cur_ts;
    bit          exp_done;

    ulpi_rx_pkt_capture dut (
        .clk_ULPI        (clk_ULPI),
        .rst             (rst),
        .enable          (enable),
        .DIR             (DIR),
        .NXT             (NXT),
        .DATA_I          (DATA_I),
        .DATA_O          (DATA_O),
        .STP             (STP),
        .data_rd_en      (data_rd_en),
        .data_o          (data_o),
        .data_vld        (data_vld),
        .data_empty      (data_empty),
        .data_level      (data_level),
        .info_rd_en      (info_rd_en),
        .info_o          (info_o),
        .info_vld        (info_vld),
        .info_empty      (info_empty),
        .linestate       (linestate),
        .vbus_state      (vbus_state),
        .rx_active       (rx_active),
        .rx_error        (rx_error),
        .host_disconnect (host_disconnect),
        .id_state        (id_state),
        .busy            (busy),
        .pkt_done        (pkt_done),
        .drop_count      (drop_count)
    );

    always #5 clk_ULPI = ~clk_ULPI;

    // Free-running cycle count since reset release, used to predict packet timestamps.
    always @(posedge clk_ULPI or negedge rst) begin
        if (!rst) tb_ts <= 16'd0;
        else      tb_ts <= tb_ts + 16'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached, want $finish earlier");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_commit();
        int          free_bytes;
        int          stored;
        logic [3:0]  fl;
        logic [10:0] lf;
        exp_done = 1'b0;
        if (cur_len == 0 && !cur_err) return;
        free_bytes = DEPTH - exp_data.size();
        stored = (cur_len < free_bytes) ? cur_len : free_bytes;
        fl = {cur_err, cur_len > free_bytes, cur_len >= LEN_MAX, cur_hd};
        lf = (cur_len >= LEN_MAX) ? 11'(LEN_MAX) : 11'(cur_len);
        if (exp_info.size() < INFO_DEPTH) begin
            exp_info.push_back({fl, lf, cur_ts});
            for (int i = 0; i < stored; i++) exp_data.push_back(cur_bytes[i]);
            exp_done = 1'b1;
        end else if (exp_drop < 65535) begin
            exp_drop++;
        end
    endfunction

    task automatic start_pkt();
        DIR = 1'b1; NXT = 1'b0; DATA_I = 8'h00;
        @(negedge clk_ULPI);
        @(negedge clk_ULPI);
        cur_bytes.delete();
        cur_len = 0; cur_err = 1'b0; cur_hd = 1'b0; cur_ts = 16'd0;
    endtask

    task automatic drive_data(input logic [7:0] b);
        DIR = 1'b1; NXT = 1'b1; DATA_I = b;
        if (cur_len == 0) cur_ts = tb_ts;
        cur_len++;
        cur_bytes.push_back(b);
        @(negedge clk_ULPI);
    endtask

    task automatic drive_cmd(input logic [7:0] c);
        DIR = 1'b1; NXT = 1'b0; DATA_I = c;
        if (c[5:4] == 2'b11) cur_err = 1'b1;
        if (c[5:4] == 2'b10) cur_hd = 1'b1;
        @(negedge clk_ULPI);
    endtask

    task automatic end_pkt(input bit by_cmd, input logic [7:0] endcmd);
        if (by_cmd) drive_cmd(endcmd);
        else begin
            DIR = 1'b0; NXT = 1'b0; DATA_I = 8'h00;
            @(negedge clk_ULPI);
        end
        DIR = 1'b0; NXT = 1'b0; DATA_I = 8'h00;
        @(negedge clk_ULPI);
        model_commit();
        compared++;
        if (pkt_done !== exp_done) begin
            mismatched++;
            $display("FAIL pkt_done_at_commit: got %b want %b", pkt_done, exp_done);
        end
        @(negedge clk_ULPI);
        compared++;
        if (pkt_done !== 1'b0) begin
            mismatched++;
            $display("FAIL pkt_done_single_pulse: got %b want 0", pkt_done);
        end
    endtask

    task automatic drain_and_verify();
        int          n;
        logic [7:0]  eb;
        logic [30:0] ei;
        compared++;
        if (data_level !== 10'(exp_data.size())) begin
            mismatched++;
            $display("FAIL data_level: got %0d want %0d", data_level, exp_data.size());
        end
        compared++;
        if (drop_count !== 16'(exp_drop)) begin
            mismatched++;
            $display("FAIL drop_count: got %0d want %0d", drop_count, exp_drop);
        end
        n = exp_data.size();
        for (int i = 0; i < n; i++) begin
            data_rd_en = 1'b1;
            @(negedge clk_ULPI);
            eb = exp_data.pop_front();
            compared++;
            if (data_vld !== 1'b1 || data_o !== eb) begin
                mismatched++;
                $display("FAIL data_pop[%0d]: got vld=%b byte=%h want vld=1 byte=%h", i, data_vld, data_o, eb);
            end
        end
        data_rd_en = 1'b0;
        @(negedge clk_ULPI);
        compared++;
        if (data_empty !== 1'b1 || data_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL data_drained: got empty=%b vld=%b want empty=1 vld=0", data_empty, data_vld);
        end
        n = exp_info.size();
        for (int i = 0; i < n; i++) begin
            info_rd_en = 1'b1;
            @(negedge clk_ULPI);
            ei = exp_info.pop_front();
            compared++;
            if (info_vld !== 1'b1 || info_o !== ei) begin
                mismatched++;
                $display("FAIL info_pop[%0d]: got vld=%b info=%h want vld=1 info=%h", i, info_vld, info_o, ei);
            end
        end
        info_rd_en = 1'b0;
        @(negedge clk_ULPI);
        compared++;
        if (info_empty !== 1'b1 || info_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL info_drained: got empty=%b vld=%b want empty=1 vld=0", info_empty, info_vld);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk_ULPI);
        compared++;
        if ({busy, data_vld, info_vld, pkt_done, rx_active, rx_error, host_disconnect,
             id_state, linestate, vbus_state} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_status: got busy=%b dv=%b iv=%b pd=%b ls=%b vb=%b want all 0",
                     busy, data_vld, info_vld, pkt_done, linestate, vbus_state);
        end
        compared++;
        if (data_empty !== 1'b1 || info_empty !== 1'b1 || data_level !== 10'd0 || drop_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_fifos: got de=%b ie=%b lvl=%0d drop=%0d want 1 1 0 0",
                     data_empty, info_empty, data_level, drop_count);
        end
        compared++;
        if (data_o !== 8'h00 || info_o !== 31'h0 || DATA_O !== 8'h00 || STP !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got data_o=%h info_o=%h DATA_O=%h STP=%b want 0",
                     data_o, info_o, DATA_O, STP);
        end
        rst = 1'b1;
        exp_data.delete(); exp_info.delete(); exp_drop = 0;
        @(negedge clk_ULPI);
    endtask

    task automatic test_basic();
        start_pkt();
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_in_packet: got %b want 1", busy);
        end
        drive_data(8'hA1);
        drive_data(8'hB2);
        drive_data(8'hC3);
        end_pkt(1'b0, 8'h00);
        drain_and_verify();
    endtask

    task automatic test_rx_error();
        start_pkt();
        drive_cmd(8'h1D);
        drive_data(8'($urandom));
        drive_cmd(8'h3D);
        compared++;
        if (rx_error !== 1'b1 || rx_active !== 1'b1 || linestate !== 2'b01 || vbus_state !== 2'b11) begin
            mismatched++;
            $display("FAIL rxcmd_error_status: got err=%b act=%b ls=%b vb=%b want 1 1 01 11",
                     rx_error, rx_active, linestate, vbus_state);
        end
        drive_data(8'($urandom));
        end_pkt(1'b0, 8'h00);
        drain_and_verify();
    endtask

    task automatic test_status_only();
        logic [7:0] cmds [3];
        logic [7:0] c;
        cmds[0] = 8'h41; cmds[1] = 8'h0E; cmds[2] = 8'h22;
        start_pkt();
        for (int i = 0; i < 3; i++) begin
            c = cmds[i];
            drive_cmd(c);
            compared++;
            if (linestate !== c[1:0] || vbus_state !== c[3:2] || id_state !== c[6] ||
                rx_active !== (c[5:4] == 2'b01 || c[5:4] == 2'b11) ||
                host_disconnect !== (c[5:4] == 2'b10) || pkt_done !== 1'b0) begin
                mismatched++;
                $display("FAIL status_only[%0d]: got ls=%b vb=%b id=%b act=%b hd=%b pd=%b for cmd %h",
                         i, linestate, vbus_state, id_state, rx_active, host_disconnect, pkt_done, c);
            end
            drive_cmd(c);
        end
        DIR = 1'b0; NXT = 1'b0; DATA_I = 8'h00;
        repeat (2) @(negedge clk_ULPI);
        compared++;
        if (info_empty !== 1'b1 || busy !== 1'b0 || data_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL status_only_no_info: got ie=%b busy=%b de=%b want 1 0 1", info_empty, busy, data_empty);
        end
        data_rd_en = 1'b1;
        @(negedge clk_ULPI);
        data_rd_en = 1'b0;
        compared++;
        if (data_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_on_empty: got data_vld=%b want 0", data_vld);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        DIR = 1'b1; NXT = 1'b0;
        repeat (2) @(negedge clk_ULPI);
        for (int i = 0; i < 3; i++) begin
            NXT = 1'b1; DATA_I = 8'($urandom);
            @(negedge clk_ULPI);
            compared++;
            if (busy !== 1'b0) begin
                mismatched++;
                $display("FAIL disabled_busy[%0d]: got %b want 0", i, busy);
            end
        end
        DIR = 1'b0; NXT = 1'b0;
        repeat (3) @(negedge clk_ULPI);
        compared++;
        if (info_empty !== 1'b1 || data_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL disabled_capture: got ie=%b de=%b want 1 1", info_empty, data_empty);
        end
        enable = 1'b1;
    endtask

    task automatic test_truncation();
        start_pkt();
        for (int i = 0; i < DEPTH + 8; i++) drive_data(8'($urandom));
        end_pkt(1'b0, 8'h00);
        drain_and_verify();
    endtask

    task automatic test_info_full();
        for (int p = 0; p < INFO_DEPTH; p++) begin
            start_pkt();
            drive_data(8'($urandom));
            end_pkt(1'b0, 8'h00);
        end
        start_pkt();
        for (int i = 0; i < 5; i++) drive_data(8'($urandom));
        end_pkt(1'b0, 8'h00);
        compared++;
        if (data_level !== 10'd32 || drop_count !== 16'd1) begin
            mismatched++;
            $display("FAIL info_full_rollback: got lvl=%0d drop=%0d want 32 1", data_level, drop_count);
        end
        drain_and_verify();
    endtask

    task automatic test_random();
        int          n;
        logic [7:0]  c;
        for (int p = 0; p < 30; p++) begin
            start_pkt();
            if ($urandom_range(0, 1) == 1) begin
                c = 8'($urandom); c[5:4] = 2'b01;
                drive_cmd(c);
            end
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    c = 8'($urandom);
                    c[5:4] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
                    drive_cmd(c);
                end
                drive_data(8'($urandom));
            end
            c = 8'($urandom);
            c[5:4] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            end_pkt($urandom_range(0, 2) == 0, c);
            if ($urandom_range(0, 1) == 1) drain_and_verify();
        end
        drain_and_verify();
    endtask

    task automatic test_reset_mid_packet();
        start_pkt();
        drive_data(8'h11);
        drive_data(8'h22);
        end_pkt(1'b0, 8'h00);
        start_pkt();
        drive_cmd(8'h5D);
        for (int i = 0; i < 4; i++) drive_data(8'($urandom));
        rst = 1'b0; DIR = 1'b0; NXT = 1'b0; DATA_I = 8'h00;
        #1;
        compared++;
        if (busy !== 1'b0 || data_empty !== 1'b1 || data_level !== 10'd0 || info_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_fifos: got busy=%b de=%b lvl=%0d ie=%b want 0 1 0 1",
                     busy, data_empty, data_level, info_empty);
        end
        compared++;
        if ({linestate, vbus_state, rx_active, id_state} !== 6'b0 || drop_count !== 16'd0) begin
            mismatched++;
            $display("FAIL mid_reset_status: got ls=%b vb=%b act=%b id=%b drop=%0d want 0",
                     linestate, vbus_state, rx_active, id_state, drop_count);
        end
        exp_data.delete(); exp_info.delete(); exp_drop = 0;
        @(negedge clk_ULPI);
        rst = 1'b1;
        repeat (2) @(negedge clk_ULPI);
        start_pkt();
        drive_data(8'h5A);
        drive_data(8'hA5);
        drive_data(8'h3C);
        end_pkt(1'b0, 8'h00);
        drain_and_verify();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rx_error();
        test_status_only();
        test_enable();
        test_truncation();
        test_info_full();
        test_random();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
